dma_write_ctrl: RTL and testbench
=================================

DMA_WRITE_CTRL -- requirements
Module: dma_write_ctrl

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, meaning the maximum beats per AXI write burst (power of 2, 1..256).
REQ-002 SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  sole clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- dma_write_valid  in  1  start request.
- dma_length_config  in  26  transfer length in bytes.
- dma_da_config  in  32  destination byte address.
- dma_idle  out  1  ready for a new request.
- DMA_IRQ  out  1  one-cycle completion pulse.
- dma_error  out  1  sticky error for the current/last transfer.
- s_axis_tdata/tvalid/tready  in/in/out  32/1/1  source data stream.
- m_axi_awaddr/awlen/awsize/awburst/awvalid/awready  out/out/out/out/out/in  32/8/3/2/1/1  AXI4 write address.
- m_axi_wdata/wstrb/wlast/wvalid/wready  out/out/out/out/in  32/4/1/1/1  AXI4 write data.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI4 write response.

Function
REQ-003 SHALL accept a request on a rising edge where dma_write_valid=1 and dma_idle=1, sampling both config inputs on that edge only.
REQ-004 SHALL ignore dma_write_valid while dma_idle=0.
REQ-005 SHALL force the low 2 bits of the sampled address to 0.
REQ-006 SHALL compute total beats as ceil(length/4).
REQ-007 SHALL implement states IDLE, ADDR, DATA, RESP, DONE:
- IDLE -> ADDR on accept.
- ADDR -> DATA on AW handshake.
- DATA -> RESP on the W handshake carrying wlast.
- RESP -> ADDR on B handshake if beats remain.
- RESP -> DONE on B handshake if no beats remain.
- DONE -> IDLE after one cycle.
REQ-008 SHALL drive dma_idle=1 only in IDLE.
REQ-009 SHALL assert awvalid in the cycle after accept (or after the previous B handshake) and hold awaddr/awlen stable until awready.
REQ-010 SHALL set burst beats = min(MAX_BURST, remaining beats, beats to next 4 KB boundary), with awlen = beats-1.
REQ-011 SHALL drive awsize=3'b010 and awburst=2'b01 constantly.
REQ-012 SHALL, in DATA only:
- drive wvalid=s_axis_tvalid, s_axis_tready=wready and wdata=s_axis_tdata combinationally;
- drive all three low outside DATA.
REQ-013 SHALL assert wlast on the final beat of each burst only.
REQ-014 SHALL drive wstrb=4'b1111 on every beat except the final beat of the transfer, where only the (length mod 4) low bytes are enabled (all four if mod=0).
REQ-015 SHALL allow exactly one outstanding burst; the next AW SHALL NOT issue before the current B handshake.
REQ-016 SHALL drive bready=1 only in RESP.
REQ-017 SHALL advance the address by 4 x burst beats after each burst.
REQ-018 SHALL set dma_error when a B handshake has bresp[1]=1.
REQ-019 SHALL NOT abort the transfer on error; dma_error SHALL clear only on the next accept.
REQ-020 SHALL pulse DMA_IRQ for exactly the one DONE cycle.
REQ-021 SHALL, for length=0, go IDLE -> DONE directly with no AXI traffic and one IRQ.
REQ-022 SHALL compute remaining-beat and address arithmetic at full width; 32-bit address wrap past 0xFFFF_FFFC wraps to 0.

Reset
REQ-023 SHALL, on an edge with RST=1 (including mid-transfer), enter IDLE with:
- dma_idle=1;
- DMA_IRQ=0, dma_error=0;
- awvalid=0, wvalid=0, bready=0, s_axis_tready=0;
- awaddr=0, awlen=0, wstrb=0, wlast=0.
REQ-024 SHALL require the AXI slave and stream source to be reset concurrently.

Verification
REQ-025 SHALL pass these scenarios:
- Scenario 1: len=0x40, addr=0x0 -> one burst: awaddr 0x0, awlen 15; wlast on beat 16; one IRQ; dma_idle high the cycle after IRQ.
- Scenario 2: len=0x90, addr=0x100 -> bursts (0x100, awlen 15), (0x140, awlen 15), (0x180, awlen 3); AW n+1 only after B n.
- Scenario 3: len=0x40, addr=0xFF8 -> bursts (0xFF8, awlen 1), (0x1000, awlen 13).
- Scenario 4: len=0x06, addr=0x20 -> awlen 1; wstrb 4'b1111 then 4'b0011; len=0 -> IRQ with no awvalid.
- Scenario 5: bresp=2'b10 on burst 1 of scenario 2 -> dma_error=1; all 3 bursts complete; IRQ; dma_error=0 after the next accept.
- Scenario 6: RST pulse during DATA -> next cycle awvalid=wvalid=s_axis_tready=0, dma_idle=1; dma_write_valid while busy produces no second burst sequence.

Source files
------------

// File: rtl/dma_write_ctrl.sv
// rtl/dma_write_ctrl.sv - stream-to-AXI4 write DMA, one outstanding burst, 4 KB-safe bursts
module dma_write_ctrl #(
    parameter int MAX_BURST = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dma_write_valid,
    input  logic [25:0] dma_length_config,
    input  logic [31:0] dma_da_config,
    output logic        dma_idle,
    output logic        DMA_IRQ,
    output logic        dma_error,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [24:0] rem_q, rem_d;
    logic [7:0]  awlen_q, awlen_d;
    logic [7:0]  beat_q, beat_d;
    logic [1:0]  mod_q, mod_d;
    logic        err_q, err_d;

    logic [24:0] start_beats;
    logic [9:0]  calc_word;
    logic [24:0] calc_rem;
    logic [10:0] to_bound;
    logic [24:0] calc_beats;
    logic [7:0]  calc_awlen;
    logic [8:0]  burst_beats;
    logic        in_data;
    logic        final_beat;
    logic [3:0]  tail_strb;
    logic        unused_bits;

    assign unused_bits = ^{m_axi_bresp[0], dma_da_config[1:0]};

    assign start_beats = {1'b0, dma_length_config[25:2]} + {24'd0, |dma_length_config[1:0]};
    assign burst_beats = {1'b0, awlen_q} + 9'd1;

    // Next burst size: in IDLE it is sized from the request being accepted, otherwise from the running state.
    always_comb begin
        calc_word  = (state_q == S_IDLE) ? dma_da_config[11:2] : addr_q[11:2];
        calc_rem   = (state_q == S_IDLE) ? start_beats : rem_q;
        to_bound   = 11'd1024 - {1'b0, calc_word};
        calc_beats = 25'(MAX_BURST);
        if ({14'd0, to_bound} < calc_beats) begin
            calc_beats = {14'd0, to_bound};
        end
        if (calc_rem < calc_beats) begin
            calc_beats = calc_rem;
        end
        calc_awlen = 8'(calc_beats - 25'd1);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        awlen_d = awlen_q;
        beat_d  = beat_q;
        mod_d   = mod_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (dma_write_valid) begin
                    err_d   = 1'b0;
                    mod_d   = dma_length_config[1:0];
                    addr_d  = {dma_da_config[31:2], 2'b00};
                    rem_d   = start_beats;
                    awlen_d = calc_awlen;
                    state_d = (start_beats == 25'd0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_axi_awready) begin
                    addr_d  = addr_q + {21'd0, burst_beats, 2'b00};
                    rem_d   = rem_q - {16'd0, burst_beats};
                    beat_d  = 8'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (s_axis_tvalid && m_axi_wready) begin
                    if (beat_q == awlen_q) begin
                        state_d = S_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp[1]) begin
                        err_d = 1'b1;
                    end
                    if (rem_q != 25'd0) begin
                        awlen_d = calc_awlen;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            rem_q   <= 25'd0;
            awlen_q <= 8'd0;
            beat_q  <= 8'd0;
            mod_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            awlen_q <= awlen_d;
            beat_q  <= beat_d;
            mod_q   <= mod_d;
            err_q   <= err_d;
        end
    end

    // rem_q is already reduced by the current burst, so zero here means this is the last burst.
    always_comb begin
        in_data    = (state_q == S_DATA);
        final_beat = in_data && (beat_q == awlen_q) && (rem_q == 25'd0);
        case (mod_q)
            2'd1:    tail_strb = 4'b0001;
            2'd2:    tail_strb = 4'b0011;
            2'd3:    tail_strb = 4'b0111;
            default: tail_strb = 4'b1111;
        endcase
    end

    assign dma_idle      = (state_q == S_IDLE);
    assign DMA_IRQ       = (state_q == S_DONE);
    assign dma_error     = err_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state_q == S_ADDR);
    assign m_axi_wvalid  = in_data && s_axis_tvalid;
    assign s_axis_tready = in_data && m_axi_wready;
    assign m_axi_wdata   = in_data ? s_axis_tdata : 32'd0;
    assign m_axi_wlast   = in_data && (beat_q == awlen_q);
    assign m_axi_wstrb   = !in_data ? 4'b0000 : (final_beat ? tail_strb : 4'b1111);
    assign m_axi_bready  = (state_q == S_RESP);

endmodule

// File: tb/tb_dma_write_ctrl.sv
// tb/tb_dma_write_ctrl.sv - scoreboard bench for dma_write_ctrl with a randomly stalling AXI slave
module tb_dma_write_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dma_write_valid;
    logic [25:0] dma_length_config;
    logic [31:0] dma_da_config;
    logic        dma_idle, DMA_IRQ, dma_error;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;

    always #5 CLK = ~CLK;

    dma_write_ctrl #(.MAX_BURST(16)) dut (
        .CLK(CLK), .RST(RST),
        .dma_write_valid(dma_write_valid), .dma_length_config(dma_length_config),
        .dma_da_config(dma_da_config), .dma_idle(dma_idle), .DMA_IRQ(DMA_IRQ),
        .dma_error(dma_error),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;
    typedef struct {
        logic [3:0] strb;
        logic       last;
    } w_t;

    aw_t aw_q[$];
    w_t  w_q[$];
    int  checks = 0;
    int  errors = 0;
    int  irq_count = 0;
    int  exp_irq = 0;
    int  b_num = 0;
    int  err_burst = -1;
    bit  b_pend = 1'b0;
    bit  outstanding = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Slave and stream source: random stalls, responses only after the burst's wlast.
    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'd0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        forever begin
            @(posedge CLK);
            #1;
            m_axi_awready = ($urandom_range(0, 3) != 0);
            m_axi_wready  = ($urandom_range(0, 3) != 0);
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            s_axis_tdata  = $urandom;
            m_axi_bvalid  = b_pend && ($urandom_range(0, 1) == 1);
            m_axi_bresp   = (b_num == err_burst) ? 2'b10 : 2'b00;
        end
    end

    // Monitor: every handshake is compared against the scoreboard queues.
    initial begin
        aw_t ea;
        w_t  ew;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (m_axi_awvalid && m_axi_awready) begin
                    if (aw_q.size() == 0) begin
                        check("aw_unexpected", {32'd0, m_axi_awaddr}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ea = aw_q.pop_front();
                        check("awaddr", m_axi_awaddr, ea.addr);
                        check("awlen", m_axi_awlen, ea.len);
                        check("awsize_awburst", {m_axi_awsize, m_axi_awburst}, 5'b010_01);
                    end
                    check("aw_while_outstanding", outstanding, 1'b0);
                    outstanding = 1'b1;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    if (w_q.size() == 0) begin
                        check("w_unexpected", {60'd0, m_axi_wstrb}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ew = w_q.pop_front();
                        check("wstrb", m_axi_wstrb, ew.strb);
                        check("wlast", m_axi_wlast, ew.last);
                    end
                    check("wdata", m_axi_wdata, s_axis_tdata);
                    if (m_axi_wlast) b_pend = 1'b1;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    b_pend      = 1'b0;
                    outstanding = 1'b0;
                    b_num++;
                end
                if (DMA_IRQ) irq_count++;
            end
        end
    end

    task automatic push_burst(input logic [31:0] a, input logic [7:0] l,
                              input logic [3:0] final_strb, input bit is_final);
        w_t e;
        aw_q.push_back('{addr: a, len: l});
        for (int i = 0; i <= int'(l); i++) begin
            e.last = (i == int'(l));
            e.strb = (is_final && e.last) ? final_strb : 4'hF;
            w_q.push_back(e);
        end
    endtask

    task automatic start(input logic [25:0] len, input logic [31:0] addr);
        @(posedge CLK);
        #2;
        check("idle_before_start", dma_idle, 1'b1);
        dma_write_valid   = 1'b1;
        dma_length_config = len;
        dma_da_config     = addr;
        exp_irq++;
        @(posedge CLK);
        #2;
        dma_write_valid   = 1'b0;
        dma_length_config = 26'(($urandom));
        dma_da_config     = $urandom;
    endtask

    task automatic wait_done(input logic exp_err);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 3000) begin
            @(negedge CLK);
            if (DMA_IRQ) seen = 1'b1;
            n++;
        end
        if (!seen) begin
            check("irq_timeout", 1'b0, 1'b1);
        end else begin
            check("error_at_irq", dma_error, exp_err);
            @(negedge CLK);
            check("idle_after_irq", {dma_idle, DMA_IRQ}, 2'b10);
            @(negedge CLK);
            check("irq_count", irq_count, exp_irq);
            check("aw_left", aw_q.size(), 0);
            check("w_left", w_q.size(), 0);
            check("outstanding_at_end", outstanding, 1'b0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_idle", dma_idle, 1'b1);
        check("rst_irq_err", {DMA_IRQ, dma_error}, 2'b00);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready}, 4'b0000);
        check("rst_awaddr_awlen", {m_axi_awaddr, m_axi_awlen}, 40'd0);
        check("rst_wstrb_wlast", {m_axi_wstrb, m_axi_wlast}, 5'd0);
    endtask

    initial begin
        int n;
        RST               = 1'b1;
        dma_write_valid   = 1'b0;
        dma_length_config = 26'd0;
        dma_da_config     = 32'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs();
        @(posedge CLK);
        #2;
        RST = 1'b0;

        // single full burst
        push_burst(32'h0, 8'd15, 4'hF, 1'b1);
        start(26'h40, 32'h0);
        wait_done(1'b0);

        // three bursts, last one short
        push_burst(32'h100, 8'd15, 4'hF, 1'b0);
        push_burst(32'h140, 8'd15, 4'hF, 1'b0);
        push_burst(32'h180, 8'd3, 4'hF, 1'b1);
        start(26'h90, 32'h100);
        wait_done(1'b0);

        // split at the 4 KB boundary
        push_burst(32'hFF8, 8'd1, 4'hF, 1'b0);
        push_burst(32'h1000, 8'd13, 4'hF, 1'b1);
        start(26'h40, 32'hFF8);
        wait_done(1'b0);

        // partial tail word, unaligned address bits dropped
        push_burst(32'h20, 8'd1, 4'b0011, 1'b1);
        start(26'h06, 32'h23);
        wait_done(1'b0);

        // zero length: IRQ only
        start(26'h0, 32'h40);
        wait_done(1'b0);

        // one-byte tail in a one-beat second burst
        push_burst(32'h0, 8'd15, 4'hF, 1'b0);
        push_burst(32'h40, 8'd0, 4'b0001, 1'b1);
        start(26'h41, 32'h0);
        wait_done(1'b0);

        // address wraps past 0xFFFF_FFFC
        push_burst(32'hFFFF_FFF8, 8'd1, 4'hF, 1'b0);
        push_burst(32'h0, 8'd1, 4'hF, 1'b1);
        start(26'h10, 32'hFFFF_FFF8);
        wait_done(1'b0);

        // slave error on the first burst: transfer still completes, error sticks
        err_burst = b_num;
        push_burst(32'h100, 8'd15, 4'hF, 1'b0);
        push_burst(32'h140, 8'd15, 4'hF, 1'b0);
        push_burst(32'h180, 8'd3, 4'hF, 1'b1);
        start(26'h90, 32'h100);
        wait_done(1'b1);
        err_burst = -1;
        check("error_held_in_idle", dma_error, 1'b1);
        push_burst(32'h0, 8'd0, 4'hF, 1'b1);
        start(26'h4, 32'h0);
        check("error_cleared_on_accept", dma_error, 1'b0);
        wait_done(1'b0);

        // reset in the middle of a data phase
        push_burst(32'h0, 8'd15, 4'hF, 1'b1);
        start(26'h40, 32'h0);
        n = 0;
        while (w_q.size() > 12 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("reached_data_phase", (w_q.size() <= 12), 1'b1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        aw_q.delete();
        w_q.delete();
        b_pend      = 1'b0;
        outstanding = 1'b0;
        exp_irq--;
        @(negedge CLK);
        check_reset_outputs();

        // requests while busy must be ignored
        push_burst(32'h200, 8'd3, 4'hF, 1'b1);
        @(posedge CLK);
        #2;
        dma_write_valid   = 1'b1;
        dma_length_config = 26'h10;
        dma_da_config     = 32'h200;
        exp_irq++;
        repeat (4) begin
            @(posedge CLK);
            #2;
            dma_length_config = 26'h80;
            dma_da_config     = 32'h4000;
        end
        dma_write_valid = 1'b0;
        wait_done(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
